// File: rtl/lsu_obi_adapter_pkg.sv
// Shared encodings and helpers for the LSU-to-OBI adapter.
package lsu_obi_adapter_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_ADDR = 2'd1,
    LSU_RESP = 2'd2,
    LSU_HOLD = 2'd3
  } lsu_state_e;

  // Natural alignment check; a byte access can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      MEM_SIZE_H: is_misaligned = off[0];
      MEM_SIZE_W: is_misaligned = |off[1:0];
      MEM_SIZE_D: is_misaligned = |off;
      default:    is_misaligned = 1'b0;
    endcase
  endfunction

  // Byte-enable pattern for an access at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_H: size_mask = 8'h03;
      MEM_SIZE_W: size_mask = 8'h0F;
      MEM_SIZE_D: size_mask = 8'hFF;
      default:    size_mask = 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/lsu_obi_adapter_load_formatter.sv
// Extracts the addressed bytes from a 64-bit read word and extends to 64 bits.
module lsu_load_formatter
  import lsu_obi_adapter_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [63:0] result_o
);

  logic [63:0] raw;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    raw = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      MEM_SIZE_B: result_o = {{56{raw[7]  & ~unsigned_i}}, raw[7:0]};
      MEM_SIZE_H: result_o = {{48{raw[15] & ~unsigned_i}}, raw[15:0]};
      MEM_SIZE_W: result_o = {{32{raw[31] & ~unsigned_i}}, raw[31:0]};
      default:    result_o = raw;
    endcase
  end

endmodule

// File: rtl/lsu_obi_adapter.sv
// Single-outstanding scalar load/store adapter feeding the OBI host driver.
module lsu_obi_adapter
  import lsu_obi_adapter_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [63:0]       req_wdata_i,
  output logic              misalign_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        be_o,
  output logic              we_o,
  output logic [63:0]       wdata_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [63:0]       rdata_i,
  output logic              load_valid_o,
  output logic [63:0]       load_data_o,
  input  logic              wb_ready_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q, uns_q, load_valid_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        be_q;
  logic [63:0]       wdata_q, load_data_q, fmt_data;
  logic              req_bad, accept;

  assign req_bad = is_misaligned(req_size_i, req_addr_i[2:0]);
  assign accept  = (state_q == LSU_IDLE) && req_valid_i && !req_bad;

  lsu_load_formatter u_fmt (
    .rdata_i    (rdata_i),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (fmt_data)
  );

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= LSU_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; stores retire at grant, loads wait for rvalid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept)     state_d = LSU_ADDR;
      LSU_ADDR: if (gnt_i)      state_d = we_q ? LSU_IDLE : LSU_RESP;
      LSU_RESP: if (rvalid_i)   state_d = LSU_HOLD;
      LSU_HOLD: if (wb_ready_i) state_d = LSU_IDLE;
      default:                  state_d = LSU_IDLE;
    endcase
  end

  // Handshake and strobe outputs decoded from state.
  always_comb begin
    req_ready_o = 1'b0;
    misalign_o  = 1'b0;
    rd_o        = 1'b0;
    wr_o        = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        req_ready_o = 1'b1;
        misalign_o  = req_valid_i && req_bad;
      end
      LSU_ADDR: begin
        rd_o = ~we_q;
        wr_o = we_q;
      end
      default: ;
    endcase
  end

  // Request capture (bus-side fields precomputed) and load result holding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= MEM_SIZE_B;
      off_q        <= 3'd0;
      addr_q       <= '0;
      be_q         <= 8'h00;
      wdata_q      <= 64'h0;
      load_valid_q <= 1'b0;
      load_data_q  <= 64'h0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        off_q   <= req_addr_i[2:0];
        addr_q  <= {req_addr_i[ADDR_W-1:3], 3'b000};
        be_q    <= size_mask(req_size_i) << req_addr_i[2:0];
        wdata_q <= req_wdata_i << {req_addr_i[2:0], 3'b000};
      end
      if (state_q == LSU_RESP && rvalid_i) begin
        load_valid_q <= 1'b1;
        load_data_q  <= fmt_data;
      end else if (state_q == LSU_HOLD && wb_ready_i) begin
        load_valid_q <= 1'b0;
      end
    end
  end

  assign addr_o       = addr_q;
  assign be_o         = be_q;
  assign we_o         = we_q;
  assign wdata_o      = wdata_q;
  assign load_valid_o = load_valid_q;
  assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_lsu_obi_adapter.sv
// Directed-vector bench for lsu_obi_adapter.
module tb_lsu_obi_adapter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = 2'd0;
  logic [63:0] req_addr_i = 64'h0, req_wdata_i = 64'h0;
  logic        req_ready_o, misalign_o, rd_o, wr_o, we_o;
  logic [63:0] addr_o, wdata_o, load_data_o;
  logic [7:0]  be_o;
  logic        gnt_i = 1'b0, rvalid_i = 1'b0, wb_ready_i = 1'b1;
  logic [63:0] rdata_i = 64'h0;
  logic        load_valid_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  lsu_obi_adapter #(.ADDR_W(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .misalign_o(misalign_o),
    .rd_o(rd_o), .wr_o(wr_o), .addr_o(addr_o), .be_o(be_o),
    .we_o(we_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .wb_ready_i(wb_ready_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven and outputs sampled off the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a request for one cycle and check that it is accepted cleanly.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz;
    req_unsigned_i = uns; req_addr_i = a; req_wdata_i = wd;
    #1;
    chk("issue_ready", {63'h0, req_ready_o}, 64'd1);
    chk("issue_misalign", {63'h0, misalign_o}, 64'd0);
    step();
    req_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_rd", {63'h0, rd_o}, 64'd0);
    chk("rst_wr", {63'h0, wr_o}, 64'd0);
    chk("rst_addr", addr_o, 64'h0);
    chk("rst_be", {56'h0, be_o}, 64'h0);
    chk("rst_lv", {63'h0, load_valid_o}, 64'd0);
    chk("rst_ld", load_data_o, 64'h0);
    rst_ni = 1'b1;
    step();

    // 1: signed byte load at offset 3, best-case latency
    issue(1'b0, 2'd0, 1'b0, 64'h1003, 64'h0);
    chk("t1_rd", {63'h0, rd_o}, 64'd1);
    chk("t1_wr", {63'h0, wr_o}, 64'd0);
    chk("t1_addr", addr_o, 64'h1000);
    chk("t1_be", {56'h0, be_o}, 64'h08);
    chk("t1_ready", {63'h0, req_ready_o}, 64'd0);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h00000000_80000000;
    #1;
    chk("t1_rd_resp", {63'h0, rd_o}, 64'd0);
    chk("t1_lv_early", {63'h0, load_valid_o}, 64'd0);
    step();
    rvalid_i = 1'b0;
    chk("t1_lv", {63'h0, load_valid_o}, 64'd1);
    chk("t1_data", load_data_o, 64'hFFFFFFFF_FFFFFF80);
    step();
    chk("t1_lv_clr", {63'h0, load_valid_o}, 64'd0);
    chk("t1_idle", {63'h0, req_ready_o}, 64'd1);

    // 2: half store at offset 6, completes at grant
    issue(1'b1, 2'd1, 1'b0, 64'h2006, 64'hBEEF);
    chk("t2_wr", {63'h0, wr_o}, 64'd1);
    chk("t2_rd", {63'h0, rd_o}, 64'd0);
    chk("t2_we", {63'h0, we_o}, 64'd1);
    chk("t2_be", {56'h0, be_o}, 64'hC0);
    chk("t2_wdata", {48'h0, wdata_o[63:48]}, 64'hBEEF);
    chk("t2_addr", addr_o, 64'h2000);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    #1;
    chk("t2_wr_off", {63'h0, wr_o}, 64'd0);
    chk("t2_ready", {63'h0, req_ready_o}, 64'd1);
    chk("t2_lv", {63'h0, load_valid_o}, 64'd0);

    // 3: unsigned word load with grant delayed three cycles
    issue(1'b0, 2'd2, 1'b1, 64'h3004, 64'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_rd_wait", {63'h0, rd_o}, 64'd1);
      chk("t3_addr_wait", addr_o, 64'h3000);
      chk("t3_be_wait", {56'h0, be_o}, 64'hF0);
      step();
    end
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'hF0000001_00000000;
    step();
    rvalid_i = 1'b0;
    chk("t3_lv", {63'h0, load_valid_o}, 64'd1);
    chk("t3_data", load_data_o, 64'h00000000_F0000001);
    step();

    // 4: dword load held in HOLD while writeback stalls
    wb_ready_i = 1'b0;
    issue(1'b0, 2'd3, 1'b0, 64'h5000, 64'h0);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h81234567_89ABCDEF;
    step();
    rvalid_i = 1'b0; rdata_i = 64'h0;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'd3;
    req_addr_i = 64'h7000; req_wdata_i = 64'h1122334455667788;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_lv_hold", {63'h0, load_valid_o}, 64'd1);
      chk("t4_data_hold", load_data_o, 64'h81234567_89ABCDEF);
      chk("t4_ready_hold", {63'h0, req_ready_o}, 64'd0);
      chk("t4_no_wr", {63'h0, wr_o}, 64'd0);
      step();
    end
    wb_ready_i = 1'b1;
    step();
    chk("t4_lv_clr", {63'h0, load_valid_o}, 64'd0);
    chk("t4_ready", {63'h0, req_ready_o}, 64'd1);
    step();
    req_valid_i = 1'b0;
    chk("t4_store_wr", {63'h0, wr_o}, 64'd1);
    chk("t4_store_addr", addr_o, 64'h7000);
    chk("t4_store_be", {56'h0, be_o}, 64'hFF);
    chk("t4_store_wdata", wdata_o, 64'h1122334455667788);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;

    // 5: misaligned word is consumed with no bus activity
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 64'h4002;
    #1;
    chk("t5_misalign", {63'h0, misalign_o}, 64'd1);
    chk("t5_ready", {63'h0, req_ready_o}, 64'd1);
    step();
    req_valid_i = 1'b0;
    #1;
    chk("t5_misalign_off", {63'h0, misalign_o}, 64'd0);
    chk("t5_rd", {63'h0, rd_o}, 64'd0);
    chk("t5_wr", {63'h0, wr_o}, 64'd0);
    chk("t5_idle", {63'h0, req_ready_o}, 64'd1);

    // 6: reset during RESP, stray rvalid afterwards, then a normal load
    issue(1'b0, 2'd3, 1'b0, 64'h8008, 64'h0);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_rd", {63'h0, rd_o}, 64'd0);
    chk("t6_rst_addr", addr_o, 64'h0);
    chk("t6_rst_be", {56'h0, be_o}, 64'h0);
    chk("t6_rst_ready", {63'h0, req_ready_o}, 64'd1);
    step();
    rst_ni = 1'b1;
    step();
    rvalid_i = 1'b1; rdata_i = 64'hDEADBEEF_DEADBEEF;
    step();
    rvalid_i = 1'b0;
    chk("t6_lv_stray", {63'h0, load_valid_o}, 64'd0);
    step();
    chk("t6_lv_stray2", {63'h0, load_valid_o}, 64'd0);
    chk("t6_ready", {63'h0, req_ready_o}, 64'd1);
    issue(1'b0, 2'd0, 1'b1, 64'h6005, 64'h0);
    chk("t6_rd", {63'h0, rd_o}, 64'd1);
    chk("t6_be", {56'h0, be_o}, 64'h20);
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h0000AB00_00000000;
    step();
    rvalid_i = 1'b0;
    chk("t6_lv", {63'h0, load_valid_o}, 64'd1);
    chk("t6_data", load_data_o, 64'h00000000_000000AB);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
